// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array sequencer.
// Drain length covers buffer latency, skew and forwarding hops.
package systolic_pkg;

    localparam int SYS_N       = 4;
    localparam int SYS_WORD    = 8;
    localparam int SYS_OUT_LAT = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_CAP,
        S_DONE
    } seq_state_t;

    function automatic int drain_cycles(input int n, input int out_lat);
        return 2 * n + out_lat;
    endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth delay line carrying a valid tag with each word.
// Output is forced to zero whenever the tag at the tail is clear.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int WORD  = 8
) (
    input  logic            clk,
    input  logic            clear,
    input  logic [WORD-1:0] d_i,
    input  logic            vld_i,
    output logic [WORD-1:0] q_o
);

    logic [WORD-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            data_q[0] <= d_i;
            vld_q[0]  <= vld_i;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
        end
    end

    assign q_o = vld_q[DEPTH-1] ? data_q[DEPTH-1] : '0;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer: clears the array, streams K skewed operand vectors,
// waits for the wavefront to drain, then pulses capture and done.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N       = SYS_N,
    parameter int WORD    = SYS_WORD,
    parameter int K_W     = 8,
    parameter int OUT_LAT = SYS_OUT_LAT
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            start,
    input  logic [K_W-1:0]  k_len,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [K_W-1:0]  rd_addr,
    input  logic [N*WORD-1:0] rd_a,
    input  logic [N*WORD-1:0] rd_b,
    output logic [N*WORD-1:0] a_edge,
    output logic [N*WORD-1:0] b_edge,
    output logic            array_clear,
    output logic            capture
);

    localparam int DRN = drain_cycles(N, OUT_LAT);
    localparam int CW  = $clog2(DRN + 1);
    localparam logic [CW-1:0]  DRN_LD = CW'(DRN - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [K_W-1:0] K_ONE  = K_W'(1);

    seq_state_t     state_q;
    logic [K_W-1:0] k_q;
    logic [K_W-1:0] rd_addr_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;
    logic           rd_en_q;
    logic           rd_vld_q;
    logic           clr_q;
    logic           cap_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            rd_addr_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_vld_q  <= 1'b0;
            clr_q     <= 1'b0;
            cap_q     <= 1'b0;
        end else begin
            // Buffer data lands one cycle after the read strobe.
            rd_vld_q <= rd_en_q;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_CLR;
                        k_q     <= k_len;
                        busy_q  <= 1'b1;
                        clr_q   <= 1'b1;
                    end
                end
                S_CLR: begin
                    clr_q <= 1'b0;
                    if (k_q != '0) begin
                        state_q   <= S_FEED;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end else begin
                        state_q <= S_DRAIN;
                        cnt_q   <= DRN_LD;
                    end
                end
                S_FEED: begin
                    if (rd_addr_q == k_q - K_ONE) begin
                        state_q   <= S_DRAIN;
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                        cnt_q     <= DRN_LD;
                    end else begin
                        rd_addr_q <= rd_addr_q + K_ONE;
                    end
                end
                S_DRAIN: begin
                    // Stays here for DRN cycles: DRN_LD down to zero.
                    if (cnt_q == '0) begin
                        state_q <= S_CAP;
                        cap_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_CAP: begin
                    state_q <= S_DONE;
                    cap_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign array_clear = clr_q;
    assign capture     = cap_q;

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(
            .DEPTH (1 + i),
            .WORD  (WORD)
        ) u_skew_a (
            .clk   (clk),
            .clear (clear),
            .d_i   (rd_a[i*WORD +: WORD]),
            .vld_i (rd_vld_q),
            .q_o   (a_edge[i*WORD +: WORD])
        );
        skew_line #(
            .DEPTH (1 + i),
            .WORD  (WORD)
        ) u_skew_b (
            .clk   (clk),
            .clear (clear),
            .d_i   (rd_b[i*WORD +: WORD]),
            .vld_i (rd_vld_q),
            .q_o   (b_edge[i*WORD +: WORD])
        );
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomized job-level bench for the systolic sequencer.
// Expected waveforms come from the cycle-timing rules per job.
module tb_systolic_seq_ctrl;

    localparam int N    = 4;
    localparam int WORD = 8;
    localparam int KW   = 8;
    localparam int OL   = 1;
    localparam int W    = N * WORD;

    logic          clk = 1'b0;
    logic          clear;
    logic          start;
    logic [KW-1:0] k_len;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [KW-1:0] rd_addr;
    logic [W-1:0]  rd_a;
    logic [W-1:0]  rd_b;
    logic [W-1:0]  a_edge;
    logic [W-1:0]  b_edge;
    logic          array_clear;
    logic          capture;

    logic [W-1:0] mem_a [256];
    logic [W-1:0] mem_b [256];

    int n_vec = 0;
    int n_err = 0;
    int cur_cyc = 0;

    systolic_seq_ctrl #(
        .N       (N),
        .WORD    (WORD),
        .K_W     (KW),
        .OUT_LAT (OL)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .k_len       (k_len),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_a        (rd_a),
        .rd_b        (rd_b),
        .a_edge      (a_edge),
        .b_edge      (b_edge),
        .array_clear (array_clear),
        .capture     (capture)
    );

    always #5 clk = ~clk;

    // Operand buffers: one-cycle read latency, junk when not read.
    always @(posedge clk) begin
        rd_a <= rd_en ? mem_a[rd_addr] : W'($urandom);
        rd_b <= rd_en ? mem_b[rd_addr] : W'($urandom);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h",
                     tag, cur_cyc, got, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_edge(input bit side_b,
                                              input int c,
                                              input int K);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = c - 4 - i;
            if (k >= 0 && k < K) begin
                if (side_b) r[i*WORD +: WORD] = mem_b[k][i*WORD +: WORD];
                else        r[i*WORD +: WORD] = mem_a[k][i*WORD +: WORD];
            end
        end
        return r;
    endfunction

    task automatic check_cycle(input int c, input int K);
        int cap_c;
        cap_c = K + 2 * N + 2 + OL;
        cur_cyc = c;
        chk("busy",  64'(busy),        64'(c >= 1 && c <= cap_c));
        chk("clr",   64'(array_clear), 64'(c == 1));
        chk("rd_en", 64'(rd_en),       64'(c >= 2 && c <= K + 1));
        if (c >= 2 && c <= K + 1)
            chk("rd_addr", 64'(rd_addr), 64'(c - 2));
        chk("capture", 64'(capture), 64'(c == cap_c));
        chk("done",    64'(done),    64'(c == cap_c + 1));
        chk("a_edge",  64'(a_edge),  64'(exp_edge(1'b0, c, K)));
        chk("b_edge",  64'(b_edge),  64'(exp_edge(1'b1, c, K)));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},  64'(busy),        64'(0));
        chk({tag, "_done"},  64'(done),        64'(0));
        chk({tag, "_rden"},  64'(rd_en),       64'(0));
        chk({tag, "_addr"},  64'(rd_addr),     64'(0));
        chk({tag, "_clr"},   64'(array_clear), 64'(0));
        chk({tag, "_cap"},   64'(capture),     64'(0));
        chk({tag, "_a"},     64'(a_edge),      64'(0));
        chk({tag, "_b"},     64'(b_edge),      64'(0));
    endtask

    task automatic fill(input int K, input bit pat);
        for (int k = 0; k < K; k++) begin
            if (pat) begin
                for (int i = 0; i < N; i++) begin
                    mem_a[k][i*WORD +: WORD] = WORD'((k << 4) | i);
                    mem_b[k][i*WORD +: WORD] = WORD'((k << 4) | i);
                end
            end else begin
                mem_a[k] = W'($urandom);
                mem_b[k] = W'($urandom);
            end
        end
    endtask

    task automatic run_job(input int K, input bit pat,
                           input bit hold, input bit chained);
        int cap_c;
        cap_c = K + 2 * N + 2 + OL;
        fill(K, pat);
        if (!chained) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        k_len = KW'(K);
        for (int c = 0; c <= cap_c + 1; c++) begin
            @(negedge clk);
            check_cycle(c, K);
            @(posedge clk);
            #1;
            if (c == 0 && !hold) start = 1'b0;
        end
    endtask

    task automatic reset_mid_feed();
        fill(8, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1;
        k_len = KW'(8);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_cycle(c, 8);
            @(posedge clk);
            #1;
            if (c == 0) start = 1'b0;
        end
        clear = 1'b1;
        cur_cyc = 4;
        @(negedge clk);
        check_zero("rst_mid");
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        clear = 1'b1;
        start = 1'b0;
        k_len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("por");
        @(posedge clk);
        #1;
        clear = 1'b0;

        run_job(4, 1'b1, 1'b0, 1'b0);
        run_job(0, 1'b0, 1'b0, 1'b0);
        reset_mid_feed();
        run_job(8, 1'b0, 1'b0, 1'b0);
        run_job(2, 1'b0, 1'b1, 1'b0);
        run_job(2, 1'b0, 1'b0, 1'b1);
        run_job(1, 1'b0, 1'b0, 1'b0);
        repeat (8) run_job(int'($urandom_range(0, 14)), 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Sequencer for the N×N systolic array of MAC processing elements. On a `start` pulse it clears the array and streams K operand vectors from the A (row) and B (column) operand buffers into the array edges with diagonal skew. It then waits for the wavefront to drain, pulses `capture` for the result collector, and signals `done`. It sits between the operand buffers and the array edge ports, and is the only block that drives the array's `clear`.

## Interface
Parameters:
- `N`, 4: array dimension; number of edge lanes on each of the A and B sides.
- `WORD`, 8: operand width per lane.
- `K_W`, 8: width of the `k_len` field and the buffer address.
- `OUT_LAT`, 1: cycles from a PE seeing its last operand pair to its `out` being valid.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `clear`, in, 1: asynchronous, active-high reset. It is also the block's own reset.
- `start`, in, 1: one-cycle request. Sampled only in IDLE.
- `k_len`, in, K_W: number of operand vectors. Sampled together with `start`.
- `busy`, out, 1: high from the cycle after `start` is accepted through the `capture` cycle.
- `done`, out, 1: one-cycle pulse in the cycle after `capture`.
- `rd_en`, out, 1: read strobe to both operand buffers.
- `rd_addr`, out, K_W: vector index, 0..k_len-1.
- `rd_a`, in, N*WORD: A buffer data. Valid in the cycle after `rd_en`.
- `rd_b`, in, N*WORD: B buffer data. Valid in the cycle after `rd_en`.
- `a_edge`, out, N*WORD: row inputs to array column 0. Lane i occupies bits [i*WORD +: WORD].
- `b_edge`, out, N*WORD: column inputs to array row 0.
- `array_clear`, out, 1: synchronous clear pulse to all PEs.
- `capture`, out, 1: one-cycle pulse; all PE outputs are final in this cycle.

## Operation
- States: IDLE → CLR → FEED → DRAIN → CAP → DONE → IDLE.
- IDLE: `start`=1 latches `k_len` into `k_reg` and moves to CLR. Otherwise the block stays in IDLE.
- CLR: exactly 1 cycle with `array_clear`=1. Go to FEED if `k_reg`≠0; if `k_reg`=0, skip FEED and go to DRAIN.
- FEED: `k_reg` cycles. Each cycle `rd_en`=1 and `rd_addr` counts 0,1,…,k_reg-1. Go to DRAIN after the last address.
- DRAIN: a down-counter loaded with 2N-2+OUT_LAT+2 runs to 0. Covers the 1 cycle of buffer latency, the lane-0 register, the N-1 cycles of skew and the N-1 forwarding hops.
- CAP: 1 cycle with `capture`=1.
- DONE: 1 cycle with `done`=1, then IDLE.
- Skew: lane i of `a_edge` and of `b_edge` equals the buffer word from one read, delayed by 1+i registers.
  - A valid tag travels with each word through the delay line.
  - A lane whose tag is 0 outputs zero, so the array only ever sees zeros outside the operand window.
- `start` outside IDLE is ignored and is not queued.
- `clear` in any state forces IDLE immediately. All counters, skew registers and tags go to 0.
- Reset values: `busy`, `done`, `rd_en`, `array_clear` and `capture` are 0; `rd_addr`, `a_edge` and `b_edge` are all zeros.
- Counters are unsigned. `rd_addr` never exceeds k_reg-1 and never wraps.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Cycle 1: `array_clear`=1, `busy`=1.
- Cycles 2..K+1: `rd_en`=1 with `rd_addr`=k in cycle 2+k.
- Vector k, lane i appears on `a_edge` and `b_edge` in cycle 4+k+i.
- `capture` is high in cycle K+2N+2+OUT_LAT. `done` is high in the next cycle; `busy` falls in that same cycle.
- A new `start` is accepted no earlier than the cycle after `done`, giving at least 1 idle cycle between jobs.

## Structure
- Shared package `systolic_pkg`:
  - state enum `seq_state_t`;
  - default constants N, WORD, OUT_LAT;
  - helper function for the drain count, 2N+OUT_LAT.
- Sub-module `skew_line`:
  - parameterized DEPTH, WORD-wide shift register with a valid tag and zero-on-invalid output;
  - instantiated 2N times with DEPTH=1+i.

## Test plan
- Reset mid-FEED: assert `clear` in cycle 4 with K=8 → all outputs are 0 in that cycle. The next `start` behaves exactly like a job from power-up.
- N=4, K=4, OUT_LAT=1: `start` in cycle 0 → `array_clear` in cycle 1; `rd_addr` 0..3 in cycles 2..5; `capture` in cycle 15; `done` in cycle 16; `busy` high for cycles 1..15.
- Skew check: buffer word = (addr<<4)|lane → `a_edge` lane 2 shows 0x02, 0x12, 0x22, 0x32 in cycles 6..9 and 0 in every other cycle.
- End to end: A = B = identity, K=4, array attached → at `capture` the PE outputs match the golden model; a second back-to-back job returns identical results, proving the clear works.
- K=0: `start` → `array_clear` in cycle 1, `rd_en` never asserts, `capture` in cycle 11, `done` in cycle 12.
- `start` held high through a K=2 job: exactly one job runs. A second job starts only if `start` is still high in IDLE after `done`.
